// File: rtl/ex.sv
// Execute stage: single-cycle ALU plus an iterative radix-2 divider.
// Ports: decoded op/operands in, RF write bundle, HI/LO bundle, stall out.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;

  localparam logic [2:0] SEL_LOGIC = 3'd1;
  localparam logic [2:0] SEL_SHIFT = 3'd2;
  localparam logic [2:0] SEL_ARITH = 3'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic        nq_q, nq_d;
  logic        nr_q, nr_d;

  logic        is_div, is_sdiv;
  logic [31:0] abs_a, abs_b;
  logic [32:0] trial, diff;
  logic [4:0]  sa;
  logic [31:0] logic_res, shift_res, arith_res, alu_res;
  logic [31:0] q_fix, r_fix;
  logic        done;

  assign sa = reg1_i[4:0];

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      OP_AND:  logic_res = reg1_i & reg2_i;
      OP_OR:   logic_res = reg1_i | reg2_i;
      OP_XOR:  logic_res = reg1_i ^ reg2_i;
      OP_NOR:  logic_res = ~(reg1_i | reg2_i);
      default: logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      OP_SLL:  shift_res = reg2_i << sa;
      OP_SRL:  shift_res = reg2_i >> sa;
      OP_SRA:  shift_res = 32'($signed(reg2_i) >>> sa);
      default: shift_res = '0;
    endcase
  end

  always_comb begin
    arith_res = '0;
    case (aluop_i)
      OP_ADDU: arith_res = reg1_i + reg2_i;
      OP_SUBU: arith_res = reg1_i - reg2_i;
      OP_SLT:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      OP_SLTU: arith_res = {31'd0, reg1_i < reg2_i};
      default: arith_res = '0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (alusel_i == SEL_LOGIC): alu_res = logic_res;
      (alusel_i == SEL_SHIFT): alu_res = shift_res;
      (alusel_i == SEL_ARITH): alu_res = arith_res;
      default:                 alu_res = '0;
    endcase
  end

  assign is_sdiv = (aluop_i == OP_DIV);
  assign is_div  = is_sdiv || (aluop_i == OP_DIVU);
  assign abs_a   = reg1_i[31] ? -reg1_i : reg1_i;
  assign abs_b   = reg2_i[31] ? -reg2_i : reg2_i;

  // Restoring step: diff[32] is the borrow, set when trial < divisor.
  assign trial = {rem_q, dvd_q[31]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    nq_d    = nq_q;
    nr_d    = nr_q;
    unique case (state_q)
      S_IDLE: begin
        if (is_div) begin
          if (reg2_i == 32'd0) begin
            state_d = S_DONE;
            dvd_d   = '1;
            rem_d   = reg1_i;
            nq_d    = 1'b0;
            nr_d    = 1'b0;
          end else begin
            state_d = S_BUSY;
            dvd_d   = is_sdiv ? abs_a : reg1_i;
            dvs_d   = is_sdiv ? abs_b : reg2_i;
            rem_d   = '0;
            cnt_d   = '0;
            nr_d    = is_sdiv & reg1_i[31];
            nq_d    = is_sdiv & (reg1_i[31] ^ reg2_i[31]);
          end
        end
      end
      S_BUSY: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          rem_d = trial[31:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      nq_q    <= 1'b0;
      nr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      nq_q    <= nq_d;
      nr_q    <= nr_d;
    end
  end

  assign q_fix = nq_q ? -dvd_q : dvd_q;
  assign r_fix = nr_q ? -rem_q : rem_q;
  assign done  = rst && (state_q == S_DONE);

  assign wd_o       = rst ? wd_i : 5'd0;
  assign wreg_o     = rst && wreg_i &&
                      ((alusel_i == SEL_LOGIC) ||
                       (alusel_i == SEL_SHIFT) ||
                       (alusel_i == SEL_ARITH));
  assign wdata_o    = rst ? alu_res : 32'd0;
  assign whilo_o    = done;
  assign hi_o       = done ? r_fix : 32'd0;
  assign lo_o       = done ? q_fix : 32'd0;
  assign stallreq_o = rst &&
                      (((state_q == S_IDLE) && is_div) ||
                       (state_q == S_BUSY));

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage pipeline, fed directly by the decode/execute pipeline register. The ALU is single-cycle combinational: logic, shift, add/subtract and set-less-than. DIV/DIVU run on an embedded iterative radix-2 divider that holds the pipeline through `stallreq_o`. Register-file write results and HI/LO write results go to the execute/memory pipeline register.

## Interface
- No parameters. Widths are fixed:
  - `RegBus` = 32
  - `AluOpBus` = 8
  - `AluSelBus` = 3
  - `RegAddrBus` = 5
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `aluop_i`  in  8  operation code. OR=0x25, AND=0x24, XOR=0x26, NOR=0x27, ADDU=0x21, SUBU=0x23, SLT=0x2A, SLTU=0x2B, SLL=0x7C, SRL=0x02, SRA=0x03, DIV=0x1A, DIVU=0x1B, NOP=0x00.
- `alusel_i`  in  3  result class. NOP=0, LOGIC=1, SHIFT=2, ARITH=4, DIV=5.
- `reg1_i`  in  32  operand A. Shift amount is `reg1_i[4:0]`; dividend for DIV/DIVU.
- `reg2_i`  in  32  operand B. Value shifted; divisor for DIV/DIVU.
- `wd_i`  in  5  destination register address.
- `wreg_i`  in  1  destination write enable.
- `wd_o`  out  5  passes `wd_i` through.
- `wreg_o`  out  1  `wreg_i`, forced to 0 for alusel NOP/DIV.
- `wdata_o`  out  32  result to write to the register file.
- `whilo_o`  out  1  HI/LO write strobe; high for exactly one cycle per division.
- `hi_o`  out  32  remainder.
- `lo_o`  out  32  quotient.
- `stallreq_o`  out  1  request to freeze PC/IF/ID/ID-EX.

## Operation
- While `rst`=0, all outputs are 0: `wd_o`, `wreg_o`, `wdata_o`, `whilo_o`, `hi_o`, `lo_o`, `stallreq_o`. The divider state is IDLE and the counter is 0.
- Logic operations are bitwise.
- Shifts:
  - SLL: `reg2<<sa`.
  - SRL: logical right shift.
  - SRA: arithmetic right shift, replicating `reg2[31]`.
- ADDU/SUBU use mod-2^32, with no overflow trap.
- SLT compares signed, SLTU compares unsigned. The result is 32'h1 or 32'h0.
- Undefined aluop within a valid alusel gives `wdata_o`=0.
- `wdata_o` is selected by `alusel_i`. It is 0 for NOP and DIV.
- Divider FSM states are IDLE, BUSY and DONE.
- IDLE:
  - If aluop is DIV/DIVU and divisor ≠ 0: latch |A| and |B| (DIV) or raw A and B (DIVU), and record the sign of A and the sign of A xor B. Clear the remainder accumulator and set counter=0. Go to BUSY.
  - If divisor = 0: go to DONE with quotient=32'hFFFF_FFFF and remainder=A.
- BUSY, one restoring step per cycle:
  - Shift {rem, dvd} left by 1.
  - If `rem ≥ divisor`: subtract the divisor and set the quotient bit.
  - Counter increments each cycle. After the step with counter=31, go to DONE.
- DONE:
  - For DIV, negate the quotient if the signs differ; the remainder takes the sign of A.
  - Drive `hi_o`/`lo_o` and `whilo_o`=1.
  - Next state is IDLE, unconditionally.
- `stallreq_o` = 1 when (IDLE and aluop is DIV/DIVU) or in BUSY. It is 0 in DONE.
- `hi_o`/`lo_o` are 0 outside DONE.
- The inputs must stay stable while `stallreq_o`=1; upstream guarantees this. Inputs that change mid-BUSY are ignored.

## Timing
- Non-divide operations:
  - Zero latency; combinational from the inputs.
  - `stallreq_o`=0.
- DIV/DIVU with non-zero divisor:
  - The op is presented in cycle 0.
  - `stallreq_o` is high in cycles 0–32, i.e. 33 cycles.
  - DONE and `whilo_o` occur in cycle 33.
  - The ID/EX register loads the next instruction at the end of cycle 33.
- Divide by zero: `stallreq_o` is high in cycle 0 only, and DONE is in cycle 1.
- Back-to-back DIVs: the second one starts in the cycle after DONE, from IDLE.
- Asynchronous reset mid-BUSY: the FSM goes to IDLE at once and `stallreq_o` drops. No `whilo_o` is produced.
- After `rst` is released, the first rising edge evaluates IDLE.

## Test plan
- Reset: hold `rst`=0 with DIV at the inputs.
  - Required: all outputs 0.
  - Then release reset. Required: `stallreq_o` goes to 1 in that cycle.
- ALU sweep (alusel and aluop set per operation):
  - OR 0x0F0F0000|0x0000F0F0 → 0x0F0FF0F0.
  - SUBU 0 − 1 → 0xFFFFFFFF.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU on the same operands → 0.
  - SRA sa=4 of 0x80000000 → 0xF8000000.
  - `wreg_o` follows `wreg_i` throughout.
- DIVU 100/7:
  - `stallreq_o` high for exactly 33 cycles.
  - Then a single `whilo_o` pulse with `lo_o`=14, `hi_o`=2.
- DIV −7/2:
  - Required: `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF.
- DIV 5/0:
  - `stallreq_o` high for 1 cycle.
  - Then `lo_o`=0xFFFFFFFF, `hi_o`=5.
- Reset asserted at BUSY counter=10, then a new DIVU 9/3 after release:
  - No `whilo_o` from the aborted division.
  - Fresh 33-cycle stall, then `lo_o`=3, `hi_o`=0.
